pixel_adjust: RTL and testbench

Brightness/contrast pixel stage sitting directly downstream of the `control` block. It consumes the single-cycle `binc`/`bdec`/`cinc`/`cdec` pulses and `frame_en`, accumulates pending adjustments, and commits them to level registers only at frame boundaries. It applies the committed levels to a streaming 24-bit RGB pixel path through a fixed 3-stage pipeline with saturation.

---
 rtl/pixel_adjust.sv | 227 ++++++++++++++++++++++
 tb/tb_pixel_adjust.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_adjust.sv
// -----------------------------------------------------------------------------
// pixel_adjust
//
// Brightness/contrast stage for a streaming 24-bit RGB pixel path.
// Up/down request pulses accumulate in small saturating pending counters and
// are folded into the committed level registers only on frame_en, so a frame
// never sees its levels change part-way through.  Each colour channel runs
// through an identical fixed 3-stage pipeline:
//   stage 1: capture pixel p
//   stage 2: m = ((p - 128) * contrast) >>> 3
//   stage 3: clamp(m + 128 + brightness, 0, 255), or p untouched if en was low
//
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous active-low reset
//   en             adjust enable, sampled with each pixel at stage 1
//   frame_en       one-cycle commit strobe
//   binc/bdec      brightness up/down request pulses
//   cinc/cdec      contrast up/down request pulses
//   in_valid       input pixel qualifier
//   in_r/g/b       unsigned 8-bit input channels
//   out_valid      in_valid delayed by 3 cycles
//   out_r/g/b      adjusted channels
//   bright_lvl     committed brightness offset, signed
//   contrast_lvl   committed contrast gain, unsigned eighths
// -----------------------------------------------------------------------------
module pixel_adjust #(
   parameter int B_STEP  = 16,
   parameter int B_MAX   = 128,
   parameter int C_RESET = 8,
   parameter int C_MAX   = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              frame_en,
   input  logic              binc,
   input  logic              bdec,
   input  logic              cinc,
   input  logic              cdec,
   input  logic              in_valid,
   input  logic [7:0]        in_r,
   input  logic [7:0]        in_g,
   input  logic [7:0]        in_b,
   output logic              out_valid,
   output logic [7:0]        out_r,
   output logic [7:0]        out_g,
   output logic [7:0]        out_b,
   output logic signed [8:0] bright_lvl,
   output logic [3:0]        contrast_lvl
);

   localparam logic signed [10:0] B_STEP_W = 11'(B_STEP);
   localparam logic signed [10:0] B_MAX_W  = 11'(B_MAX);
   localparam logic signed [5:0]  C_MAX_W  = 6'(C_MAX);

   // ---------------------------------------------------------------------
   // Pending counters and committed levels
   // ---------------------------------------------------------------------
   logic signed [3:0] pend_b_q, pend_b_d;
   logic signed [3:0] pend_c_q, pend_c_d;
   logic signed [8:0] bright_lvl_q, bright_lvl_d;
   logic [3:0]        contrast_lvl_q, contrast_lvl_d;
   logic signed [10:0] b_sum;
   logic signed [5:0]  c_sum;

   // On a commit cycle the counter restarts from zero, so a pulse arriving
   // together with frame_en becomes the next frame's pending value.
   function automatic logic signed [3:0] pend_next(
      input logic signed [3:0] cur,
      input logic              up,
      input logic              dn,
      input logic              commit
   );
      logic signed [3:0] base;
      base = commit ? 4'sd0 : cur;
      if (up && !dn && base < 4'sd7) begin
         pend_next = base + 4'sd1;
      end else if (dn && !up && base > -4'sd7) begin
         pend_next = base - 4'sd1;
      end else begin
         pend_next = base;
      end
   endfunction

   always_comb begin
      pend_b_d       = pend_next(pend_b_q, binc, bdec, frame_en);
      pend_c_d       = pend_next(pend_c_q, cinc, cdec, frame_en);
      bright_lvl_d   = bright_lvl_q;
      contrast_lvl_d = contrast_lvl_q;

      b_sum = 11'(bright_lvl_q) + 11'(pend_b_q) * B_STEP_W;
      c_sum = $signed({2'b00, contrast_lvl_q}) + 6'(pend_c_q);

      if (frame_en) begin
         if (b_sum > B_MAX_W) begin
            bright_lvl_d = 9'(B_MAX_W);
         end else if (b_sum < -B_MAX_W) begin
            bright_lvl_d = 9'(-B_MAX_W);
         end else begin
            bright_lvl_d = 9'(b_sum);
         end

         if (c_sum < 6'sd0) begin
            contrast_lvl_d = 4'd0;
         end else if (c_sum > C_MAX_W) begin
            contrast_lvl_d = 4'(C_MAX_W);
         end else begin
            contrast_lvl_d = 4'(c_sum);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_b_q       <= '0;
         pend_c_q       <= '0;
         bright_lvl_q   <= '0;
         contrast_lvl_q <= 4'(C_RESET);
      end else begin
         pend_b_q       <= pend_b_d;
         pend_c_q       <= pend_c_d;
         bright_lvl_q   <= bright_lvl_d;
         contrast_lvl_q <= contrast_lvl_d;
      end
   end

   assign bright_lvl   = bright_lvl_q;
   assign contrast_lvl = contrast_lvl_q;

   // ---------------------------------------------------------------------
   // Control pipeline: valid and enable travel alongside each pixel
   // ---------------------------------------------------------------------
   logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic en1_q, en1_d, en2_q, en2_d;

   always_comb begin
      v1_d  = in_valid;
      v2_d  = v1_q;
      v3_d  = v2_q;
      en1_d = en;
      en2_d = en1_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         v3_q  <= 1'b0;
         en1_q <= 1'b0;
         en2_q <= 1'b0;
      end else begin
         v1_q  <= v1_d;
         v2_q  <= v2_d;
         v3_q  <= v3_d;
         en1_q <= en1_d;
         en2_q <= en2_d;
      end
   end

   assign out_valid = v3_q;

   // ---------------------------------------------------------------------
   // Per-channel datapath (0 = red, 1 = green, 2 = blue)
   // ---------------------------------------------------------------------
   logic [7:0] pix_in  [3];
   logic [7:0] pix_out [3];

   assign pix_in[0] = in_r;
   assign pix_in[1] = in_g;
   assign pix_in[2] = in_b;

   for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic [7:0]         p1_q, p1_d;
      logic [7:0]         p2_q, p2_d;
      logic signed [8:0]  m2_q, m2_d;
      logic [7:0]         o_q, o_d;
      logic signed [8:0]  d;
      logic signed [12:0] d_ext;
      logic signed [12:0] g_ext;
      logic signed [12:0] prod;
      logic signed [10:0] s;

      always_comb begin
         p1_d  = pix_in[gi];
         d     = $signed({1'b0, p1_q}) - 9'sd128;
         d_ext = 13'(d);
         g_ext = {9'd0, contrast_lvl_q};
         prod  = d_ext * g_ext;
         // Arithmetic shift floors toward minus infinity; |result| <= 240.
         m2_d  = 9'(prod >>> 3);
         p2_d  = p1_q;

         s = 11'(m2_q) + 11'sd128 + 11'(bright_lvl_q);
         if (!en2_q) begin
            o_d = p2_q;
         end else if (s < 11'sd0) begin
            o_d = 8'd0;
         end else if (s > 11'sd255) begin
            o_d = 8'd255;
         end else begin
            o_d = s[7:0];
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            p1_q <= '0;
            p2_q <= '0;
            m2_q <= '0;
            o_q  <= '0;
         end else begin
            p1_q <= p1_d;
            p2_q <= p2_d;
            m2_q <= m2_d;
            o_q  <= o_d;
         end
      end

      assign pix_out[gi] = o_q;
   end

   assign out_r = pix_out[0];
   assign out_g = pix_out[1];
   assign out_b = pix_out[2];

endmodule

// File: tb/tb_pixel_adjust.sv
// -----------------------------------------------------------------------------
// tb_pixel_adjust
//
// Directed bench for pixel_adjust: hand-computed pixel vectors streamed through
// the pipeline plus level/pending-counter scenarios, reset and enable gating.
// -----------------------------------------------------------------------------
module tb_pixel_adjust;

   logic              clk;
   logic              rst;
   logic              en;
   logic              frame_en;
   logic              binc, bdec, cinc, cdec;
   logic              in_valid;
   logic [7:0]        in_r, in_g, in_b;
   logic              out_valid;
   logic [7:0]        out_r, out_g, out_b;
   logic signed [8:0] bright_lvl;
   logic [3:0]        contrast_lvl;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      bit          en;
      byte unsigned r, g, b;
      byte unsigned xr, xg, xb;
   } vec_t;

   vec_t vq[$];

   pixel_adjust dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .frame_en     (frame_en),
      .binc         (binc),
      .bdec         (bdec),
      .cinc         (cinc),
      .cdec         (cdec),
      .in_valid     (in_valid),
      .in_r         (in_r),
      .in_g         (in_g),
      .in_b         (in_b),
      .out_valid    (out_valid),
      .out_r        (out_r),
      .out_g        (out_g),
      .out_b        (out_b),
      .bright_lvl   (bright_lvl),
      .contrast_lvl (contrast_lvl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input bit bi, input bit bd, input bit ci, input bit cd,
                       input bit fe, input int n);
      binc = bi; bdec = bd; cinc = ci; cdec = cd; frame_en = fe;
      repeat (n) tick();
      binc = 0; bdec = 0; cinc = 0; cdec = 0; frame_en = 0;
   endtask

   task automatic commit();
      hold(0, 0, 0, 0, 1, 1);
   endtask

   task automatic do_reset();
      rst = 0; en = 1; frame_en = 0;
      binc = 0; bdec = 0; cinc = 0; cdec = 0;
      in_valid = 0; in_r = 0; in_g = 0; in_b = 0;
      tick();
      tick();
      rst = 1;
      tick();
   endtask

   task automatic add(input bit e, input int r, input int g, input int b,
                      input int xr, input int xg, input int xb);
      vec_t v;
      v.en = e;
      v.r = 8'(r);   v.g = 8'(g);   v.b = 8'(b);
      v.xr = 8'(xr); v.xg = 8'(xg); v.xb = 8'(xb);
      vq.push_back(v);
   endtask

   // Drive queued vectors back to back; after the k-th clock edge the output
   // belongs to the pixel driven two iterations earlier (3-cycle latency).
   task automatic run_stream(input string tag);
      int n;
      n = vq.size();
      for (int k = 0; k < n + 3; k++) begin
         if (k < n) begin
            in_valid = 1;
            en   = vq[k].en;
            in_r = vq[k].r; in_g = vq[k].g; in_b = vq[k].b;
         end else begin
            in_valid = 0;
            en = 1;
            in_r = 0; in_g = 0; in_b = 0;
         end
         tick();
         check({tag, ".valid"}, int'(out_valid), (k >= 2 && k - 2 < n) ? 1 : 0);
         if (k >= 2 && k - 2 < n) begin
            check($sformatf("%s.r[%0d]", tag, k - 2), int'(out_r), int'(vq[k-2].xr));
            check($sformatf("%s.g[%0d]", tag, k - 2), int'(out_g), int'(vq[k-2].xg));
            check($sformatf("%s.b[%0d]", tag, k - 2), int'(out_b), int'(vq[k-2].xb));
         end
      end
      vq.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // ---------------- reset state and bypass ----------------
      do_reset();
      check("rst.out_valid", int'(out_valid), 0);
      check("rst.out_r", int'(out_r), 0);
      check("rst.bright", int'(bright_lvl), 0);
      check("rst.contrast", int'(contrast_lvl), 8);
      add(1, 0, 37, 128, 0, 37, 128);
      add(1, 200, 255, 0, 200, 255, 0);
      add(1, 128, 37, 255, 128, 37, 255);
      run_stream("bypass");

      // ---------------- brightness commit ----------------
      hold(1, 0, 0, 0, 0, 3);
      check("bri.pre", int'(bright_lvl), 0);
      frame_en = 1;
      check("bri.fe_cycle", int'(bright_lvl), 0);
      tick();
      frame_en = 0;
      check("bri.lvl", int'(bright_lvl), 48);
      add(1, 200, 230, 0, 248, 255, 48);
      add(1, 128, 255, 20, 176, 255, 68);
      run_stream("bri");

      // ---------------- contrast ----------------
      do_reset();
      hold(0, 0, 1, 0, 0, 4);
      commit();
      check("con.lvl", int'(contrast_lvl), 12);
      add(1, 200, 0, 128, 236, 0, 128);
      add(1, 100, 255, 64, 86, 255, 32);
      add(1, 101, 129, 127, 87, 129, 126);
      run_stream("con");

      // ---------------- limits and collisions ----------------
      do_reset();
      hold(0, 1, 0, 0, 0, 20);
      commit();
      check("lim.b_sat7", int'(bright_lvl), -112);
      add(1, 100, 255, 200, 0, 143, 88);
      run_stream("lim1");
      hold(0, 1, 0, 0, 0, 20);
      commit();
      check("lim.b_clamp", int'(bright_lvl), -128);
      hold(1, 1, 0, 0, 0, 3);
      commit();
      check("lim.b_cancel", int'(bright_lvl), -128);
      add(1, 100, 255, 128, 0, 127, 0);
      run_stream("lim2");
      hold(0, 0, 1, 0, 1, 1);
      check("lim.c_fe_same", int'(contrast_lvl), 8);
      commit();
      check("lim.c_carry", int'(contrast_lvl), 9);
      commit();
      check("lim.c_b2b", int'(contrast_lvl), 9);
      hold(0, 0, 0, 1, 0, 20);
      commit();
      check("lim.c_dec7", int'(contrast_lvl), 2);
      hold(0, 0, 0, 1, 0, 20);
      commit();
      check("lim.c_floor", int'(contrast_lvl), 0);
      add(1, 0, 255, 77, 0, 0, 0);
      run_stream("lim3");
      hold(0, 0, 1, 0, 0, 20);
      commit();
      check("lim.c_inc7", int'(contrast_lvl), 7);
      hold(0, 0, 1, 0, 0, 20);
      commit();
      check("lim.c_inc14", int'(contrast_lvl), 14);
      hold(0, 0, 1, 0, 0, 20);
      commit();
      check("lim.c_ceil", int'(contrast_lvl), 15);

      // ---------------- enable gating ----------------
      do_reset();
      hold(1, 0, 0, 0, 0, 3);
      commit();
      check("ena.lvl", int'(bright_lvl), 48);
      add(1, 10, 100, 200, 58, 148, 248);
      add(0, 10, 100, 200, 10, 100, 200);
      add(1, 250, 0, 128, 255, 48, 176);
      add(0, 250, 0, 128, 250, 0, 128);
      add(1, 1, 2, 3, 49, 50, 51);
      run_stream("ena");

      // ---------------- async reset mid-stream ----------------
      do_reset();
      hold(1, 0, 1, 0, 0, 3);
      commit();
      check("ars.pre_b", int'(bright_lvl), 48);
      hold(1, 0, 1, 0, 0, 2);
      in_valid = 1; en = 1;
      in_r = 200; in_g = 100; in_b = 50;
      repeat (4) tick();
      check("ars.busy", int'(out_valid), 1);
      #2;
      rst = 0;
      #1;
      check("ars.valid", int'(out_valid), 0);
      check("ars.out_r", int'(out_r), 0);
      check("ars.out_g", int'(out_g), 0);
      check("ars.out_b", int'(out_b), 0);
      check("ars.bright", int'(bright_lvl), 0);
      check("ars.contrast", int'(contrast_lvl), 8);
      in_valid = 0;
      tick();
      tick();
      rst = 1;
      tick();
      check("ars.no_flush", int'(out_valid), 0);
      commit();
      check("ars.pend_lost_b", int'(bright_lvl), 0);
      check("ars.pend_lost_c", int'(contrast_lvl), 8);
      add(1, 37, 200, 9, 37, 200, 9);
      run_stream("ars");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
